crt_tint_mapper: RTL and testbench

- Parametrised successor of the combinational mono/green-screen colour mapper that sits between the CPC video RGB outputs and the OSD overlay / scandoubler.
- Adds a registered 2-stage pipeline and sync/blank alignment.
- Adds four selectable monitor modes: colour, green, amber, grey.
- Mode changes are keyboard-driven and applied only at frame boundaries, so there is no mid-frame tearing.

---
 rtl/crt_tint_mapper.sv | 207 ++++++++++++++++++++
 tb/tb_crt_tint_mapper.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/crt_tint_mapper.sv
// CPC video colour mapper: 2-stage pixel pipeline with colour/green/amber/grey monitor modes.
// Optional scanline dimming is built when the macro SCANLINE_DIM_EN is defined.
module crt_tint_mapper #(
  parameter int CW         = 3,
  parameter int RESET_MODE = 0,
  parameter int IMMEDIATE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [CW-1:0] ri,
  input  logic [CW-1:0] gi,
  input  logic [CW-1:0] bi,
  input  logic          hsync_n_i,
  input  logic          vsync_n_i,
  input  logic          blank_i,
  input  logic          mono_force,
  input  logic          mode_cycle,
  input  logic          mode_load,
  input  logic [1:0]    mode_val,
  input  logic          scan_dim_on,
  output logic [CW-1:0] ro,
  output logic [CW-1:0] go,
  output logic [CW-1:0] bo,
  output logic          hsync_n_o,
  output logic          vsync_n_o,
  output logic          blank_o,
  output logic [1:0]    mode_o,
  output logic          mode_pending
);

  localparam int SW = CW + 4;
  localparam logic [1:0] MODE_COLOUR = 2'd0;
  localparam logic [1:0] MODE_GREEN  = 2'd1;
  localparam logic [1:0] MODE_AMBER  = 2'd2;
  localparam logic [1:0] MODE_GREY   = 2'd3;
  localparam logic [1:0] MODE_RESET  = 2'(RESET_MODE);

  logic [1:0] req_mode, act_mode, req_next, act_next, eff_mode;
  logic       cyc_prev, vs_prev, cyc_rise, vs_fall;

  assign cyc_rise = mode_cycle & ~cyc_prev;
  assign vs_fall  = pix_en & vs_prev & ~vsync_n_i;

  // A load in the same clk as a cycle edge wins and swallows the edge.
  always_comb begin
    req_next = req_mode;
    if (mode_load)
      req_next = mode_val;
    else if (cyc_rise)
      req_next = req_mode + 2'd1;
  end

  always_comb begin
    act_next = act_mode;
    if (IMMEDIATE != 0 || vs_fall)
      act_next = req_mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_mode     <= MODE_RESET;
      act_mode     <= MODE_RESET;
      cyc_prev     <= 1'b0;
      vs_prev      <= 1'b0;
      mode_pending <= 1'b0;
    end else begin
      req_mode     <= req_next;
      act_mode     <= act_next;
      cyc_prev     <= mode_cycle;
      if (pix_en)
        vs_prev <= vsync_n_i;
      mode_pending <= (req_next != act_next);
    end
  end

  assign eff_mode = (act_mode == MODE_COLOUR && mono_force) ? MODE_GREEN : act_mode;
  assign mode_o   = eff_mode;

  // Luma weights 5/9/2 sum to 16, so the shifted sum always fits in CW bits.
  logic [SW-1:0] luma_sum;
  logic [CW-1:0] y_next;

  always_comb begin
    luma_sum = ({4'b0, ri} << 2) + {4'b0, ri}
             + ({4'b0, gi} << 3) + {4'b0, gi}
             + ({4'b0, bi} << 1);
    y_next   = CW'(luma_sum >> 4);
  end

  logic [CW-1:0] r1, g1, b1, y1;
  logic          hs1, vs1, bl1, par1;

`ifdef SCANLINE_DIM_EN
  logic hs_prev, parity, parity_next;

  // Vsync restarts the line count; the pixel on the hsync edge belongs to the new line.
  always_comb begin
    parity_next = parity;
    if (pix_en && vs_fall)
      parity_next = 1'b0;
    else if (pix_en && hsync_n_i && !hs_prev)
      parity_next = ~parity;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev <= 1'b0;
      parity  <= 1'b0;
    end else if (pix_en) begin
      hs_prev <= hsync_n_i;
      parity  <= parity_next;
    end
  end
`else
  logic parity_next;
  logic unused_scan_dim;
  assign parity_next     = 1'b0;
  assign unused_scan_dim = scan_dim_on;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r1   <= '0;
      g1   <= '0;
      b1   <= '0;
      y1   <= '0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      bl1  <= 1'b1;
      par1 <= 1'b0;
    end else if (pix_en) begin
      r1   <= ri;
      g1   <= gi;
      b1   <= bi;
      y1   <= y_next;
      hs1  <= hsync_n_i;
      vs1  <= vsync_n_i;
      bl1  <= blank_i;
      par1 <= parity_next;
    end
  end

  logic [CW-1:0] map_r, map_g, map_b;

  // Tint mapping, then optional scanline dim, then blank forces black.
  always_comb begin
    map_r = r1;
    map_g = g1;
    map_b = b1;
    case (eff_mode)
      MODE_GREEN: begin
        map_r = y1 >> 2;
        map_g = y1;
        map_b = y1 >> 3;
      end
      MODE_AMBER: begin
        map_r = y1;
        map_g = y1 - (y1 >> 2);
        map_b = '0;
      end
      MODE_GREY: begin
        map_r = y1;
        map_g = y1;
        map_b = y1;
      end
      default: ;
    endcase
`ifdef SCANLINE_DIM_EN
    if (scan_dim_on && par1) begin
      map_r = map_r >> 1;
      map_g = map_g >> 1;
      map_b = map_b >> 1;
    end
`else
    if (par1) begin
      map_r = map_r >> 1;
      map_g = map_g >> 1;
      map_b = map_b >> 1;
    end
`endif
    if (bl1) begin
      map_r = '0;
      map_g = '0;
      map_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ro        <= '0;
      go        <= '0;
      bo        <= '0;
      hsync_n_o <= 1'b1;
      vsync_n_o <= 1'b1;
      blank_o   <= 1'b1;
    end else if (pix_en) begin
      ro        <= map_r;
      go        <= map_g;
      bo        <= map_b;
      hsync_n_o <= hs1;
      vsync_n_o <= vs1;
      blank_o   <= bl1;
    end
  end

endmodule

// File: tb/tb_crt_tint_mapper.sv
// Directed bench for crt_tint_mapper (CW=3, colour reset mode, vsync-committed modes).
module tb_crt_tint_mapper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b1;
  logic [2:0] ri = '0, gi = '0, bi = '0;
  logic       hsync_n_i = 1'b1, vsync_n_i = 1'b1, blank_i = 1'b0;
  logic       mono_force = 1'b0, mode_cycle = 1'b0, mode_load = 1'b0;
  logic [1:0] mode_val = '0;
  logic       scan_dim_on = 1'b0;
  logic [2:0] ro, go, bo;
  logic       hsync_n_o, vsync_n_o, blank_o, mode_pending;
  logic [1:0] mode_o;

  int errors = 0;
  int checks = 0;

  crt_tint_mapper dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .ri(ri), .gi(gi), .bi(bi),
    .hsync_n_i(hsync_n_i), .vsync_n_i(vsync_n_i), .blank_i(blank_i),
    .mono_force(mono_force), .mode_cycle(mode_cycle), .mode_load(mode_load),
    .mode_val(mode_val), .scan_dim_on(scan_dim_on),
    .ro(ro), .go(go), .bo(bo),
    .hsync_n_o(hsync_n_o), .vsync_n_o(vsync_n_o), .blank_o(blank_o),
    .mode_o(mode_o), .mode_pending(mode_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                               input logic hs, input logic vs, input logic bl);
    ri = r; gi = g; bi = b;
    hsync_n_i = hs; vsync_n_i = vs; blank_i = bl;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {23'b0, ro, go, bo};
  endfunction

  initial begin
    tick();
    tick();
    checkOutput("reset_rgb", rgb(), 32'h000);
    checkOutput("reset_syncs", {29'b0, hsync_n_o, vsync_n_o, blank_o}, 32'h7);
    checkOutput("reset_mode", {30'b0, mode_o}, 32'd0);
    checkOutput("reset_pending", {31'b0, mode_pending}, 32'd0);
    rst = 1'b0;

    // Colour passthrough and 2-clk latency
    applyStimulus(3'd2, 3'd5, 3'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("lat1_hs", {31'b0, hsync_n_o}, 32'd1);
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("colour_253", rgb(), {23'b0, 3'd2, 3'd5, 3'd3});
    checkOutput("hs_delay", {31'b0, hsync_n_o}, 32'd0);
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("hs_release", {31'b0, hsync_n_o}, 32'd1);

    // Load green mid-frame: pending until vsync
    mode_load = 1'b1; mode_val = 2'd1;
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    mode_load = 1'b0;
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("pend_set", {31'b0, mode_pending}, 32'd1);
    checkOutput("pend_mode", {30'b0, mode_o}, 32'd0);
    checkOutput("pend_colour", rgb(), {23'b0, 3'd7, 3'd7, 3'd7});
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd2, 3'd5, 3'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("green_777", rgb(), {23'b0, 3'd1, 3'd7, 3'd0});
    checkOutput("green_mode", {30'b0, mode_o}, 32'd1);
    checkOutput("green_pend", {31'b0, mode_pending}, 32'd0);
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("green_253", rgb(), {23'b0, 3'd0, 3'd3, 3'd0});

    // One short pulse plus one held level: two edges, green -> grey
    mode_cycle = 1'b1;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    mode_cycle = 1'b0;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    mode_cycle = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    mode_cycle = 1'b0;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("cycle_pend", {31'b0, mode_pending}, 32'd1);
    checkOutput("cycle_hold_mode", {30'b0, mode_o}, 32'd1);
    applyStimulus(3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd0, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("grey_400", rgb(), {23'b0, 3'd1, 3'd1, 3'd1});
    checkOutput("grey_mode", {30'b0, mode_o}, 32'd3);
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("grey_040", rgb(), {23'b0, 3'd2, 3'd2, 3'd2});

    // Load and cycle edge together: load wins (amber, not colour)
    mode_load = 1'b1; mode_val = 2'd2; mode_cycle = 1'b1;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    mode_load = 1'b0;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    mode_cycle = 1'b0;
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b1);
    checkOutput("amber_777", rgb(), {23'b0, 3'd7, 3'd6, 3'd0});
    checkOutput("amber_blank0", {31'b0, blank_o}, 32'd0);
    checkOutput("amber_mode", {30'b0, mode_o}, 32'd2);
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("blank_rgb", rgb(), 32'h000);
    checkOutput("blank_flag", {31'b0, blank_o}, 32'd1);

    // Back to colour, then mono_force overrides without vsync
    mode_load = 1'b1; mode_val = 2'd0;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    mode_load = 1'b0;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("colour_back", {30'b0, mode_o}, 32'd0);
    mono_force = 1'b1;
    #1;
    checkOutput("mono_mode", {30'b0, mode_o}, 32'd1);
    applyStimulus(3'd2, 3'd5, 3'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("mono_253", rgb(), {23'b0, 3'd0, 3'd3, 3'd0});
    pix_en = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("stall_hold", rgb(), {23'b0, 3'd0, 3'd3, 3'd0});
    checkOutput("stall_hs", {31'b0, hsync_n_o}, 32'd1);
    pix_en = 1'b1;
    applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("stall_resume", rgb(), {23'b0, 3'd1, 3'd7, 3'd0});
    mono_force = 1'b0;

    // Reset mid-line
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("rst_rgb", rgb(), 32'h000);
    checkOutput("rst_syncs", {29'b0, hsync_n_o, vsync_n_o, blank_o}, 32'h7);
    rst = 1'b0;

`ifdef SCANLINE_DIM_EN
    scan_dim_on = 1'b1;
    mode_load = 1'b1; mode_val = 2'd3;
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    mode_load = 1'b0;
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0);
    checkOutput("scan_line0", rgb(), {23'b0, 3'd7, 3'd7, 3'd7});
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0);
    checkOutput("scan_line1", rgb(), {23'b0, 3'd3, 3'd3, 3'd3});
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("scan_line2", rgb(), {23'b0, 3'd7, 3'd7, 3'd7});
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("scan_odd", rgb(), {23'b0, 3'd3, 3'd3, 3'd3});
    applyStimulus(3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("scan_vs_clear", rgb(), {23'b0, 3'd7, 3'd7, 3'd7});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
